// File: rtl/bg_fb_pkg.sv
// Shared constants and types for the background frame-buffer writer.
// Screen geometry, buffer select codes and writer FSM states.
package bg_fb_pkg;

  localparam int FB_WIDTH  = 320;
  localparam int FB_HEIGHT = 240;

  localparam logic [1:0] BG_INVALID = 2'd3;

  typedef enum logic [1:0] {
    BG_START    = 2'd0,
    BG_INGAME   = 2'd1,
    BG_GAMEOVER = 2'd2
  } bg_sel_t;

  typedef enum logic [1:0] {
    IDLE,
    CLIP,
    RUN,
    FIN
  } wr_state_t;

endpackage

// File: rtl/bg_rect_clip.sv
// Combinational clip of a rectangle to the 320x240 screen.
// In: x0/y0/w/h. Out: exclusive x_end/y_end and an empty flag.
module bg_rect_clip
  import bg_fb_pkg::*;
(
  input  logic [8:0] x0,
  input  logic [7:0] y0,
  input  logic [8:0] w,
  input  logic [7:0] h,
  output logic [9:0] x_end,
  output logic [8:0] y_end,
  output logic       empty
);

  localparam logic [9:0] FB_W = 10'(FB_WIDTH);
  localparam logic [8:0] FB_H = 9'(FB_HEIGHT);

  logic [9:0] x_sum;
  logic [8:0] y_sum;

  always_comb begin
    x_sum = {1'b0, x0} + {1'b0, w};
    y_sum = {1'b0, y0} + {1'b0, h};
    x_end = (x_sum > FB_W) ? FB_W : x_sum;
    y_end = (y_sum > FB_H) ? FB_H : y_sum;
    empty = (w == 9'd0) || (h == 8'd0) ||
            ({1'b0, x0} >= FB_W) || ({1'b0, y0} >= FB_H);
  end

endmodule

// File: rtl/bg_fb_writer.sv
// Rectangle-fill writer into the 4-bit background frame buffers.
// Ports: cmd_* valid/ready command in, write_* pixel strobe out, busy/done/cmd_err.
module bg_fb_writer
  import bg_fb_pkg::*;
#(
  parameter int ADDR_W = 19,
  parameter int DATA_W = 4
) (
  input  logic              Clk,
  input  logic              Reset_n,
  input  logic              cmd_valid,
  output logic              cmd_ready,
  input  logic [8:0]        cmd_x0,
  input  logic [7:0]        cmd_y0,
  input  logic [8:0]        cmd_w,
  input  logic [7:0]        cmd_h,
  input  logic [DATA_W-1:0] cmd_color,
  input  logic [1:0]        cmd_bg_sel,
  input  logic              write_allow,
  output logic              write_en,
  output logic [ADDR_W-1:0] write_address,
  output logic [DATA_W-1:0] write_data,
  output logic [1:0]        write_sel,
  output logic              busy,
  output logic              done,
  output logic              cmd_err
);

  wr_state_t state_q, state_d;

  logic [8:0]        x0_q, x0_d;
  logic [7:0]        y0_q, y0_d;
  logic [8:0]        w_q, w_d;
  logic [7:0]        h_q, h_d;
  logic [DATA_W-1:0] color_q, color_d;
  logic [1:0]        sel_q, sel_d;

  logic [8:0]  x_q, x_d;
  logic [7:0]  y_q, y_d;
  logic [16:0] row_q, row_d;

  logic              we_q, we_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [DATA_W-1:0] data_q, data_d;
  logic [1:0]        wsel_q, wsel_d;
  logic              busy_q, busy_d;
  logic              done_q, done_d;
  logic              err_q, err_d;
  logic              rdy_q, rdy_d;

  logic [9:0] x_end;
  logic [8:0] y_end;
  logic       empty;

  bg_rect_clip u_clip (
    .x0    (x0_q),
    .y0    (y0_q),
    .w     (w_q),
    .h     (h_q),
    .x_end (x_end),
    .y_end (y_end),
    .empty (empty)
  );

  always_comb begin
    state_d = state_q;
    x0_d    = x0_q;
    y0_d    = y0_q;
    w_d     = w_q;
    h_d     = h_q;
    color_d = color_q;
    sel_d   = sel_q;
    x_d     = x_q;
    y_d     = y_q;
    row_d   = row_q;
    we_d    = 1'b0;
    addr_d  = addr_q;
    data_d  = data_q;
    wsel_d  = wsel_q;
    unique case (state_q)
      IDLE: begin
        if (cmd_valid && rdy_q) begin
          x0_d    = cmd_x0;
          y0_d    = cmd_y0;
          w_d     = cmd_w;
          h_d     = cmd_h;
          color_d = cmd_color;
          sel_d   = cmd_bg_sel;
          state_d = CLIP;
        end
      end
      CLIP: begin
        if (empty || sel_q == BG_INVALID) begin
          state_d = FIN;
        end else begin
          x_d     = x0_q;
          y_d     = y0_q;
          // y0*320 as (y0<<8)+(y0<<6)
          row_d   = 17'({y0_q, 8'd0}) + 17'({y0_q, 6'd0});
          state_d = RUN;
        end
      end
      RUN: begin
        if (write_allow) begin
          we_d   = 1'b1;
          addr_d = ADDR_W'(row_q) + ADDR_W'(x_q);
          data_d = color_q;
          wsel_d = sel_q;
          if ({1'b0, x_q} + 10'd1 == x_end) begin
            x_d   = x0_q;
            y_d   = y_q + 8'd1;
            row_d = row_q + 17'(FB_WIDTH);
            if ({1'b0, y_q} + 9'd1 == y_end) begin
              state_d = FIN;
            end
          end else begin
            x_d = x_q + 9'd1;
          end
        end
      end
      FIN: begin
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
    rdy_d  = (state_d == IDLE);
    busy_d = (state_d != IDLE);
    // done lands after the final write has left the output register
    done_d = (state_q == FIN);
    err_d  = (state_q == FIN) && (sel_q == BG_INVALID);
  end

  always_ff @(posedge Clk or negedge Reset_n) begin
    if (!Reset_n) begin
      state_q <= IDLE;
      x0_q    <= '0;
      y0_q    <= '0;
      w_q     <= '0;
      h_q     <= '0;
      color_q <= '0;
      sel_q   <= '0;
      x_q     <= '0;
      y_q     <= '0;
      row_q   <= '0;
      we_q    <= 1'b0;
      addr_q  <= '0;
      data_q  <= '0;
      wsel_q  <= '0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      err_q   <= 1'b0;
      rdy_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      x0_q    <= x0_d;
      y0_q    <= y0_d;
      w_q     <= w_d;
      h_q     <= h_d;
      color_q <= color_d;
      sel_q   <= sel_d;
      x_q     <= x_d;
      y_q     <= y_d;
      row_q   <= row_d;
      we_q    <= we_d;
      addr_q  <= addr_d;
      data_q  <= data_d;
      wsel_q  <= wsel_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
      err_q   <= err_d;
      rdy_q   <= rdy_d;
    end
  end

  assign cmd_ready     = rdy_q;
  assign write_en      = we_q;
  assign write_address = addr_q;
  assign write_data    = data_q;
  assign write_sel     = wsel_q;
  assign busy          = busy_q;
  assign done          = done_q;
  assign cmd_err       = err_q;

endmodule

// File: tb/tb_bg_fb_writer.sv
// Scoreboard bench for bg_fb_writer.
// Directed rectangle fills; a negedge monitor pops expected writes/done events.
module tb_bg_fb_writer;

  logic        Clk;
  logic        Reset_n;
  logic        cmd_valid;
  logic        cmd_ready;
  logic [8:0]  cmd_x0;
  logic [7:0]  cmd_y0;
  logic [8:0]  cmd_w;
  logic [7:0]  cmd_h;
  logic [3:0]  cmd_color;
  logic [1:0]  cmd_bg_sel;
  logic        write_allow;
  logic        write_en;
  logic [18:0] write_address;
  logic [3:0]  write_data;
  logic [1:0]  write_sel;
  logic        busy;
  logic        done;
  logic        cmd_err;

  bg_fb_writer dut (
    .Clk           (Clk),
    .Reset_n       (Reset_n),
    .cmd_valid     (cmd_valid),
    .cmd_ready     (cmd_ready),
    .cmd_x0        (cmd_x0),
    .cmd_y0        (cmd_y0),
    .cmd_w         (cmd_w),
    .cmd_h         (cmd_h),
    .cmd_color     (cmd_color),
    .cmd_bg_sel    (cmd_bg_sel),
    .write_allow   (write_allow),
    .write_en      (write_en),
    .write_address (write_address),
    .write_data    (write_data),
    .write_sel     (write_sel),
    .busy          (busy),
    .done          (done),
    .cmd_err       (cmd_err)
  );

  initial Clk = 1'b0;
  always #5 Clk = ~Clk;

  typedef struct {
    int addr;
    int data;
    int sel;
  } wr_t;

  wr_t wq[$];
  int  dq[$];
  int  n_tests = 0;
  int  n_fail = 0;
  int  done_seen = 0;
  bit  ignore_writes = 1'b0;

  task automatic check(input string name, input int act, input int exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic pushw(input int a, input int d, input int s);
    wr_t e;
    e.addr = a;
    e.data = d;
    e.sel  = s;
    wq.push_back(e);
  endtask

  // monitor
  initial begin
    forever begin
      @(negedge Clk);
      if (Reset_n) begin
        if (write_en) begin
          check("addr_range", int'(write_address <= 19'd76799), 1);
          if (!ignore_writes) begin
            if (wq.size() == 0) begin
              check("spurious_write", wq.size(), 1);
            end else begin
              wr_t e;
              e = wq.pop_front();
              check("write_address", int'(write_address), e.addr);
              check("write_data", int'(write_data), e.data);
              check("write_sel", int'(write_sel), e.sel);
            end
          end
        end
        if (done) begin
          done_seen++;
          check("we_during_done", int'(write_en), 0);
          if (dq.size() == 0) begin
            check("spurious_done", dq.size(), 1);
          end else begin
            check("cmd_err", int'(cmd_err), dq.pop_front());
          end
        end else if (cmd_err) begin
          check("err_without_done", int'(done), 1);
        end
      end
    end
  end

  task automatic send(input int x0, input int y0, input int w,
                      input int h, input int c, input int s);
    int n;
    n = 0;
    @(negedge Clk);
    while (!cmd_ready && n < 200) begin
      @(negedge Clk);
      n++;
    end
    check("cmd_ready_wait", int'(cmd_ready), 1);
    cmd_x0     = 9'(x0);
    cmd_y0     = 8'(y0);
    cmd_w      = 9'(w);
    cmd_h      = 8'(h);
    cmd_color  = 4'(c);
    cmd_bg_sel = 2'(s);
    cmd_valid  = 1'b1;
    @(posedge Clk);
    #1 cmd_valid = 1'b0;
  endtask

  task automatic wait_done(input string name, input int bound);
    int target;
    target = done_seen + 1;
    for (int i = 0; i < bound && done_seen < target; i++) @(negedge Clk);
    @(negedge Clk);
    check(name, int'(done_seen >= target), 1);
  endtask

  int pat[6] = '{1, 0, 0, 1, 1, 1};

  initial begin
    Reset_n     = 1'b0;
    cmd_valid   = 1'b0;
    cmd_x0      = '0;
    cmd_y0      = '0;
    cmd_w       = '0;
    cmd_h       = '0;
    cmd_color   = '0;
    cmd_bg_sel  = '0;
    write_allow = 1'b1;
    repeat (3) @(negedge Clk);
    check("rst_cmd_ready", int'(cmd_ready), 0);
    check("rst_write_en", int'(write_en), 0);
    check("rst_busy", int'(busy), 0);
    check("rst_done", int'(done), 0);
    check("rst_addr", int'(write_address), 0);
    Reset_n = 1'b1;
    @(posedge Clk);
    #1 check("ready_after_rst", int'(cmd_ready), 1);

    // basic fill with latency check
    pushw(1610, 7, 1); pushw(1611, 7, 1); pushw(1612, 7, 1);
    pushw(1930, 7, 1); pushw(1931, 7, 1); pushw(1932, 7, 1);
    dq.push_back(0);
    send(10, 5, 3, 2, 7, 1);
    check("busy_in_clip", int'(busy), 1);
    check("ready_low_busy", int'(cmd_ready), 0);
    @(posedge Clk);
    #1 check("lat_n1_we", int'(write_en), 0);
    @(posedge Clk);
    #1 check("lat_n2_we", int'(write_en), 1);
    wait_done("done_fill", 50);

    // clipped at the bottom-right corner
    pushw(76798, 12, 2); pushw(76799, 12, 2);
    dq.push_back(0);
    send(318, 239, 5, 5, 12, 2);
    wait_done("done_clip", 50);

    // empty commands
    dq.push_back(0);
    send(20, 20, 0, 4, 3, 0);
    wait_done("done_empty_w", 20);
    check("ready_after_empty_w", int'(cmd_ready), 1);
    dq.push_back(0);
    send(320, 10, 4, 4, 3, 0);
    wait_done("done_empty_x", 20);
    check("ready_after_empty_x", int'(cmd_ready), 1);

    // invalid buffer select
    dq.push_back(1);
    send(0, 0, 2, 2, 5, 3);
    wait_done("done_bad_sel", 20);

    // write_allow stalls mid-row
    pushw(100, 4, 0); pushw(101, 4, 0);
    pushw(102, 4, 0); pushw(103, 4, 0);
    dq.push_back(0);
    send(100, 0, 4, 1, 4, 0);
    write_allow = 1'b0;
    @(posedge Clk);
    foreach (pat[i]) begin
      @(negedge Clk);
      write_allow = pat[i][0];
      @(posedge Clk);
      #1 check("stall_we", int'(write_en), pat[i]);
    end
    write_allow = 1'b1;
    wait_done("done_stall", 20);

    // reset mid full-screen fill
    ignore_writes = 1'b1;
    send(0, 0, 320, 240, 9, 2);
    repeat (50) @(posedge Clk);
    #1 check("pre_rst_we", int'(write_en), 1);
    #2 Reset_n = 1'b0;
    #1;
    check("arst_we", int'(write_en), 0);
    check("arst_addr", int'(write_address), 0);
    check("arst_data", int'(write_data), 0);
    check("arst_sel", int'(write_sel), 0);
    check("arst_busy", int'(busy), 0);
    check("arst_ready", int'(cmd_ready), 0);
    check("arst_done", int'(done), 0);
    repeat (2) @(negedge Clk);
    ignore_writes = 1'b0;
    Reset_n = 1'b1;
    @(posedge Clk);
    #1 check("ready_after_arst", int'(cmd_ready), 1);
    pushw(645, 3, 2);
    dq.push_back(0);
    send(5, 2, 1, 1, 3, 2);
    wait_done("done_1x1", 20);

    repeat (3) @(negedge Clk);
    check("writes_left", wq.size(), 0);
    check("dones_left", dq.size(), 0);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

endmodule
